// File: rtl/painter_pkg.sv
// painter_pkg: shared state encoding, wall palette and RGB565 helpers for column_painter
package painter_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, PAINT, DONE} state_t;
  localparam int R_LSB = 11;
  localparam int R_W = 5;
  localparam int G_LSB = 5;
  localparam int G_W = 6;
  localparam int B_LSB = 0;
  localparam int B_W = 5;
  localparam logic [15:0] PALETTE [16] = '{
    16'hF800, 16'h07E0, 16'h001F, 16'hFFE0, 16'hF81F, 16'h07FF, 16'h8C51, 16'hFC00,
    16'h03EF, 16'h7800, 16'h01E0, 16'h000F, 16'hC618, 16'hFD20, 16'hAFE5, 16'hFFFF
  };
  // each channel shifts on its own so no bits bleed into the neighbouring field
  function automatic logic [15:0] rgb565_shr(input logic [15:0] c, input logic [1:0] n);
    return {c[R_LSB +: R_W] >> n, c[G_LSB +: G_W] >> n, c[B_LSB +: B_W] >> n};
  endfunction
endpackage

// File: rtl/column_painter.sv
// column_painter: paints one framebuffer column (ceiling, wall, floor) per DDA ray.
// Define PAINTER_FOG_EN to darken distant wall pixels.
module column_painter
  import painter_pkg::*;
#(
  parameter int SCREEN_WIDTH = 320,
  parameter int SCREEN_HEIGHT = 240,
  parameter logic [15:0] CEIL_COLOR = 16'h2104,
  parameter logic [15:0] FLOOR_COLOR = 16'h4208,
  localparam int AW = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT)
) (
  input  logic          pixel_clk_in,
  input  logic          rst_in,
  input  logic          dda_out_tvalid,
  input  logic [37:0]   dda_out_tdata,
  input  logic          dda_out_tlast,
  output logic          dda_out_tready,
  input  logic          fb_ready_in,
  output logic          fb_we_out,
  output logic [AW-1:0] fb_addr_out,
  output logic [15:0]   fb_data_out,
  output logic          frame_done_out
);
  localparam logic [8:0] W9 = 9'(SCREEN_WIDTH);
  localparam logic [7:0] H8 = 8'(SCREEN_HEIGHT);
  localparam logic [AW-1:0] WA = AW'(SCREEN_WIDTH);
  state_t r_state, w_nxt;
  logic [8:0] r_hc;
  logic [7:0] r_lh, r_row;
  logic [3:0] r_map;
  logic r_wt, r_last, r_we, r_done, r_tready;
  logic [AW-1:0] r_addr;
  logic [15:0] r_data;
  logic w_xfer, w_acc, w_unused;
  logic [7:0] w_lh, w_ds, w_de, w_row_n;
  logic [15:0] w_shade, w_wall, w_color;
  assign w_xfer = dda_out_tvalid & r_tready;
  assign w_acc = r_we & fb_ready_in;
  assign w_unused = ^dda_out_tdata[15:0];
  assign dda_out_tready = r_tready;
  assign fb_we_out = r_we;
  assign fb_addr_out = r_addr;
  assign fb_data_out = r_data;
  assign frame_done_out = r_done;
  // colour is computed for the row that will be presented next, since data is registered
  always_comb begin
    w_lh = r_lh >= H8 ? H8 : r_lh;
    w_ds = (H8 - w_lh) >> 1;
    w_de = w_ds + w_lh;
    w_row_n = r_state == SETUP ? 8'd0 : r_row + 8'd1;
    w_shade = rgb565_shr(PALETTE[r_map], {1'b0, r_wt});
`ifdef PAINTER_FOG_EN
    w_wall = rgb565_shr(w_shade, r_lh < 8'd60 ? 2'd2 : r_lh < 8'd120 ? 2'd1 : 2'd0);
`else
    w_wall = w_shade;
`endif
    w_color = w_row_n < w_ds ? CEIL_COLOR : w_row_n < w_de ? w_wall : FLOOR_COLOR;
    w_nxt = r_state == IDLE ? (w_xfer ? SETUP : IDLE) :
            r_state == SETUP ? (r_hc >= W9 ? DONE : PAINT) :
            r_state == PAINT ? (w_acc && r_row == H8 - 8'd1 ? DONE : PAINT) : IDLE;
  end
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      r_state <= IDLE;
      r_tready <= 1'b0;
      r_we <= 1'b0;
      r_done <= 1'b0;
      r_hc <= '0;
      r_lh <= '0;
      r_wt <= 1'b0;
      r_map <= '0;
      r_last <= 1'b0;
      r_row <= '0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_state <= w_nxt;
      r_tready <= w_nxt == IDLE;
      r_we <= w_nxt == PAINT;
      r_done <= w_nxt == DONE && r_last;
      if (w_xfer) begin
        {r_hc, r_lh, r_wt, r_map} <= dda_out_tdata[37:16];
        r_last <= dda_out_tlast;
      end
      r_row <= r_state == SETUP ? 8'd0 : w_acc ? w_row_n : r_row;
      r_addr <= w_nxt != PAINT ? '0 : r_state == SETUP ? AW'(r_hc) : w_acc ? r_addr + WA : r_addr;
      r_data <= w_nxt != PAINT ? 16'd0 : r_state == SETUP || w_acc ? w_color : r_data;
    end
  end
endmodule
